// File: rtl/rv_decode_pkg.sv
// RV32I decode helpers: opcode constants, immediate format selection and operand-use queries.
package rv_decode_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpMisc   = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OpLui || op == OpAuipc || op == OpJal);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op == OpBranch || op == OpStore || op == OpOp;
  endfunction

  // Opcode includes instr[1:0], so a non-11 low pair can never match a legal entry.
  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad, OpStore,
      OpOpImm, OpOp, OpMisc, OpSystem: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    case (op)
      OpJalr, OpLoad, OpOpImm, OpSystem: return ImmI;
      OpStore:                           return ImmS;
      OpBranch:                          return ImmB;
      OpLui, OpAuipc:                    return ImmU;
      OpJal:                             return ImmJ;
      default:                           return ImmNone;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the format from the opcode and sign-extends to XLEN.
module imm_gen
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm
);

  imm_fmt_e    w_fmt;
  logic [31:0] w_imm32;

  assign w_fmt = imm_fmt(i_instr[6:0]);

  always_comb begin
    w_imm32 = '0;
    unique case (w_fmt)
      ImmI:    w_imm32 = {{21{i_instr[31]}}, i_instr[30:20]};
      ImmS:    w_imm32 = {{21{i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
      ImmB:    w_imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      ImmU:    w_imm32 = {i_instr[31:12], 12'b0};
      ImmJ:    w_imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline register with forwarding, load-use stall, flush and immediate selection.
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_BYP = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [XLEN-1:0]           i_in_pc,
  input  logic [31:0]               i_in_instr,
  output logic [REG_AW-1:0]         o_rf_rs1_addr,
  output logic [REG_AW-1:0]         o_rf_rs2_addr,
  input  logic [XLEN-1:0]           i_rf_rs1_data,
  input  logic [XLEN-1:0]           i_rf_rs2_data,
  input  logic [NUM_BYP-1:0]        i_byp_valid,
  input  logic [NUM_BYP*REG_AW-1:0] i_byp_addr,
  input  logic [NUM_BYP*XLEN-1:0]   i_byp_data,
  input  logic                      i_byp0_is_load,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [XLEN-1:0]           o_out_pc,
  output logic [XLEN-1:0]           o_out_rs1_data,
  output logic [XLEN-1:0]           o_out_rs2_data,
  output logic [XLEN-1:0]           o_out_imm,
  output logic [6:0]                o_out_opcode,
  output logic [2:0]                o_out_funct3,
  output logic [6:0]                o_out_funct7,
  output logic [REG_AW-1:0]         o_out_rd_addr,
  output logic [REG_AW-1:0]         o_out_rs1_addr,
  output logic [REG_AW-1:0]         o_out_rs2_addr,
  output logic [11:0]               o_out_csr_addr,
  output logic [XLEN-1:0]           o_out_uimm,
  output logic                      o_out_illegal
);

  logic [6:0]        w_opcode;
  logic [REG_AW-1:0] w_rs1, w_rs2, w_rd, w_byp0_addr;
  logic [XLEN-1:0]   w_imm;
  logic              w_hazard, w_load;
  logic [XLEN-1:0]   w_chain1 [NUM_BYP+1];
  logic [XLEN-1:0]   w_chain2 [NUM_BYP+1];

  assign w_opcode      = i_in_instr[6:0];
  assign w_rd          = REG_AW'(i_in_instr[11:7]);
  assign w_rs1         = REG_AW'(i_in_instr[19:15]);
  assign w_rs2         = REG_AW'(i_in_instr[24:20]);
  assign w_byp0_addr   = i_byp_addr[REG_AW-1:0];
  assign o_rf_rs1_addr = w_rs1;
  assign o_rf_rs2_addr = w_rs2;

  assign w_hazard = i_in_valid & i_byp_valid[0] & i_byp0_is_load & (w_byp0_addr != '0) &
                    ((uses_rs1(w_opcode) & (w_byp0_addr == w_rs1)) |
                     (uses_rs2(w_opcode) & (w_byp0_addr == w_rs2)));

  assign o_in_ready = (!o_out_valid | i_out_ready) & !w_hazard & !i_flush;
  assign w_load     = i_in_valid & o_in_ready;

  // Chain is built from the oldest source down so index 0 ends up with the final say.
  assign w_chain1[NUM_BYP] = (w_rs1 == '0) ? '0 : i_rf_rs1_data;
  assign w_chain2[NUM_BYP] = (w_rs2 == '0) ? '0 : i_rf_rs2_data;

  for (genvar g = 0; g < NUM_BYP; g++) begin : g_fwd
    logic [REG_AW-1:0] w_addr;
    logic [XLEN-1:0]   w_data;
    assign w_addr = i_byp_addr[g*REG_AW +: REG_AW];
    assign w_data = i_byp_data[g*XLEN +: XLEN];
    assign w_chain1[g] = (i_byp_valid[g] && w_addr == w_rs1 && w_rs1 != '0) ? w_data
                                                                             : w_chain1[g+1];
    assign w_chain2[g] = (i_byp_valid[g] && w_addr == w_rs2 && w_rs2 != '0) ? w_data
                                                                             : w_chain2[g+1];
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (i_in_instr),
    .o_imm   (w_imm)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_valid    <= 1'b0;
      o_out_pc       <= '0;
      o_out_rs1_data <= '0;
      o_out_rs2_data <= '0;
      o_out_imm      <= '0;
      o_out_opcode   <= '0;
      o_out_funct3   <= '0;
      o_out_funct7   <= '0;
      o_out_rd_addr  <= '0;
      o_out_rs1_addr <= '0;
      o_out_rs2_addr <= '0;
      o_out_csr_addr <= '0;
      o_out_uimm     <= '0;
      o_out_illegal  <= 1'b0;
    end else if (i_flush) begin
      o_out_valid <= 1'b0;
    end else if (w_load) begin
      o_out_valid    <= 1'b1;
      o_out_pc       <= i_in_pc;
      o_out_rs1_data <= w_chain1[0];
      o_out_rs2_data <= w_chain2[0];
      o_out_imm      <= w_imm;
      o_out_opcode   <= w_opcode;
      o_out_funct3   <= i_in_instr[14:12];
      o_out_funct7   <= i_in_instr[31:25];
      o_out_rd_addr  <= w_rd;
      o_out_rs1_addr <= w_rs1;
      o_out_rs2_addr <= w_rs2;
      o_out_csr_addr <= i_in_instr[31:20];
      o_out_uimm     <= XLEN'(i_in_instr[19:15]);
      o_out_illegal  <= !is_legal(w_opcode);
    end else if (i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one task per scenario with hand-computed expectations.
module tb_decode_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NUM_BYP = 2;

  logic                      clk, rst_n, flush, in_valid, in_ready;
  logic [XLEN-1:0]           in_pc;
  logic [31:0]               in_instr;
  logic [REG_AW-1:0]         rf_rs1_addr, rf_rs2_addr;
  logic [XLEN-1:0]           rf_rs1_data, rf_rs2_data;
  logic [NUM_BYP-1:0]        byp_valid;
  logic [NUM_BYP*REG_AW-1:0] byp_addr;
  logic [NUM_BYP*XLEN-1:0]   byp_data;
  logic                      byp0_is_load, out_valid, out_ready;
  logic [XLEN-1:0]           out_pc, out_rs1_data, out_rs2_data, out_imm, out_uimm;
  logic [6:0]                out_opcode, out_funct7;
  logic [2:0]                out_funct3;
  logic [REG_AW-1:0]         out_rd_addr, out_rs1_addr, out_rs2_addr;
  logic [11:0]               out_csr_addr;
  logic                      out_illegal;

  int total = 0;
  int bad = 0;

  decode_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_BYP(NUM_BYP)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flush        (flush),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_pc        (in_pc),
    .i_in_instr     (in_instr),
    .o_rf_rs1_addr  (rf_rs1_addr),
    .o_rf_rs2_addr  (rf_rs2_addr),
    .i_rf_rs1_data  (rf_rs1_data),
    .i_rf_rs2_data  (rf_rs2_data),
    .i_byp_valid    (byp_valid),
    .i_byp_addr     (byp_addr),
    .i_byp_data     (byp_data),
    .i_byp0_is_load (byp0_is_load),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_pc       (out_pc),
    .o_out_rs1_data (out_rs1_data),
    .o_out_rs2_data (out_rs2_data),
    .o_out_imm      (out_imm),
    .o_out_opcode   (out_opcode),
    .o_out_funct3   (out_funct3),
    .o_out_funct7   (out_funct7),
    .o_out_rd_addr  (out_rd_addr),
    .o_out_rs1_addr (out_rs1_addr),
    .o_out_rs2_addr (out_rs2_addr),
    .o_out_csr_addr (out_csr_addr),
    .o_out_uimm     (out_uimm),
    .o_out_illegal  (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    flush = 0; in_valid = 0; in_pc = '0; in_instr = 32'h0000_0013;
    rf_rs1_data = '0; rf_rs2_data = '0; byp_valid = '0; byp_addr = '0; byp_data = '0;
    byp0_is_load = 0; out_ready = 1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_pc !== '0) begin bad++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    total++; if (out_imm !== '0) begin bad++; $display("FAIL reset_imm got=%h exp=0", out_imm); end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_addi();
    in_valid = 1; in_instr = 32'hFFB1_0093; in_pc = 32'h100; rf_rs1_data = 7; rf_rs2_data = 32'h99;
    #1;
    total++; if (rf_rs1_addr !== 5'd2) begin bad++; $display("FAIL rf_rs1_addr got=%0d exp=2", rf_rs1_addr); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL addi_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
    total++; if (out_imm !== 32'hFFFF_FFFB) begin bad++; $display("FAIL addi_imm got=%h exp=fffffffb", out_imm); end
    total++; if (out_rs1_data !== 32'd7) begin bad++; $display("FAIL addi_rs1 got=%h exp=7", out_rs1_data); end
    total++; if (out_rs2_data !== 32'h99) begin bad++; $display("FAIL addi_rs2 got=%h exp=99", out_rs2_data); end
    total++; if (out_rd_addr !== 5'd1 || out_pc !== 32'h100 || out_opcode !== 7'h13)
      begin bad++; $display("FAIL addi_fields got rd=%0d pc=%h op=%h exp rd=1 pc=100 op=13", out_rd_addr, out_pc, out_opcode); end
    in_valid = 0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bubble_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_fwd_priority();
    in_valid = 1; in_instr = 32'h0010_81B3; rf_rs1_data = 32'h11; rf_rs2_data = 32'h22;
    byp_valid = 2'b11; byp_addr = {5'd1, 5'd1}; byp_data = {32'hBB, 32'hAA};
    tick();
    total++; if (out_rs1_data !== 32'hAA || out_rs2_data !== 32'hAA)
      begin bad++; $display("FAIL fwd_prio got=%h/%h exp=aa/aa", out_rs1_data, out_rs2_data); end
    byp_valid = 2'b10;
    tick();
    total++; if (out_rs1_data !== 32'hBB || out_rs2_data !== 32'hBB)
      begin bad++; $display("FAIL fwd_src1 got=%h/%h exp=bb/bb", out_rs1_data, out_rs2_data); end
  endtask

  task automatic test_x0();
    in_instr = 32'h0000_01B3; rf_rs1_data = 32'h1234; rf_rs2_data = 32'h5678;
    byp_valid = 2'b01; byp_addr = '0; byp_data = {32'h0, 32'h55}; byp0_is_load = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (out_rs1_data !== '0 || out_rs2_data !== '0)
      begin bad++; $display("FAIL x0_data got=%h/%h exp=0/0", out_rs1_data, out_rs2_data); end
  endtask

  task automatic test_load_use();
    in_instr = 32'h0053_2023; in_pc = 32'h300; rf_rs1_data = 32'h600; rf_rs2_data = 32'h777;
    byp_valid = 2'b01; byp_addr = {5'd0, 5'd5}; byp_data = {32'h0, 32'hDEAD}; byp0_is_load = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_stall got=%b exp=0", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%b exp=0", out_valid); end
    byp0_is_load = 0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_rs2_data !== 32'hDEAD || out_rs1_data !== 32'h600)
      begin bad++; $display("FAIL lu_accept got v=%b rs1=%h rs2=%h exp v=1 rs1=600 rs2=dead", out_valid, out_rs1_data, out_rs2_data); end
    total++; if (out_imm !== '0 || out_opcode !== 7'h23 || out_pc !== 32'h300)
      begin bad++; $display("FAIL lu_fields got imm=%h op=%h pc=%h exp imm=0 op=23 pc=300", out_imm, out_opcode, out_pc); end
    byp_valid = '0;
  endtask

  task automatic test_stall();
    in_instr = 32'hFFB1_0093; in_pc = 32'h200; rf_rs1_data = 7;
    tick();
    out_ready = 0; in_instr = 32'h1234_53B7; in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready%0d got=%b exp=0", i, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_imm !== 32'hFFFF_FFFB)
        begin bad++; $display("FAIL stall_hold%0d got v=%b pc=%h imm=%h exp v=1 pc=200 imm=fffffffb", i, out_valid, out_pc, out_imm); end
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (out_pc !== 32'h204 || out_imm !== 32'h1234_5000 || out_rd_addr !== 5'd7)
      begin bad++; $display("FAIL release_load got pc=%h imm=%h rd=%0d exp pc=204 imm=12345000 rd=7", out_pc, out_imm, out_rd_addr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [4];
    logic [31:0] imms [4];
    instrs = '{32'hFE20_8EE3, 32'h0080_00EF, 32'h0020_A623, 32'h3051_10F3};
    imms   = '{32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_000C, 32'h0000_0305};
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_instr = instrs[i]; in_pc = 32'h400 + 4 * i;
      tick();
      total++; if (out_valid !== 1'b1 || out_imm !== imms[i] || out_pc !== 32'h400 + 4 * i)
        begin bad++; $display("FAIL b2b_%0d got v=%b imm=%h exp v=1 imm=%h", i, out_valid, out_imm, imms[i]); end
    end
    total++; if (out_csr_addr !== 12'h305 || out_uimm !== 32'd2 || out_funct3 !== 3'd1)
      begin bad++; $display("FAIL csr_fields got csr=%h uimm=%h f3=%0d exp csr=305 uimm=2 f3=1", out_csr_addr, out_uimm, out_funct3); end
  endtask

  task automatic test_flush_illegal();
    flush = 1; in_instr = 32'hFFB1_0093;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    flush = 0; in_instr = 32'h0000_000B;
    tick();
    total++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_imm !== '0)
      begin bad++; $display("FAIL illegal got v=%b ill=%b imm=%h exp v=1 ill=1 imm=0", out_valid, out_illegal, out_imm); end
    in_instr = 32'hFFB1_0093;
    tick();
    total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL legal got=%b exp=0", out_illegal); end
  endtask

  task automatic test_reset_mid();
    rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0 || out_pc !== '0 || out_rs1_data !== '0)
      begin bad++; $display("FAIL mid_reset got v=%b pc=%h rs1=%h exp 0", out_valid, out_pc, out_rs1_data); end
    set_idle();
    tick();
    rst_n = 1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fwd_priority();
    test_x0();
    test_load_use();
    test_stall();
    test_back_to_back();
    test_flush_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
